q_update_engine: RTL

//  Parametrised Q-learning update engine. Computes
//  Q_new = Q_cur + alpha*(target - Q_cur), where target = reward + gamma*max_a Q_next[a].

---
 rtl/q_learn_pkg.sv | 30 +++
 rtl/q_fixed_mul_sat.sv | 29 ++
 rtl/q_update_engine.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/q_learn_pkg.sv
// Shared types and helpers for the Q-learning update engine.
// Holds the FSM state encoding and the signed clamp used by every stage.
package q_learn_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SCAN,
        TGT,
        UPD,
        OUT
    } state_t;

    // Clamp a wide signed value into a signed field of 'width' bits.
    function automatic logic signed [63:0] sat_fx(
        input logic signed [63:0] value,
        input int                 width
    );
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (width - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        if (value > hi)
            sat_fx = hi;
        else if (value < lo)
            sat_fx = lo;
        else
            sat_fx = value;
    endfunction

endpackage

// File: rtl/q_fixed_mul_sat.sv
// Signed fixed-point multiply: p = sat((a*b) >>> FRAC_W), ovf when clamped.
// Ports: a, b (DATA_W signed operands), p (DATA_W signed result), ovf (clamp hit).
module q_fixed_mul_sat #(
    parameter int DATA_W = 16,
    parameter int FRAC_W = 12
) (
    input  logic signed [DATA_W-1:0] a,
    input  logic signed [DATA_W-1:0] b,
    output logic signed [DATA_W-1:0] p,
    output logic                     ovf
);
    import q_learn_pkg::*;

    localparam int PW = 2 * DATA_W;

    logic signed [PW-1:0] prod;
    logic signed [PW-1:0] shifted;
    logic signed [63:0]   wide;
    logic signed [63:0]   clamped;

    assign prod    = PW'(a) * PW'(b);
    // Arithmetic shift gives floor rounding of the scaled product.
    assign shifted = prod >>> FRAC_W;
    assign wide    = 64'(shifted);
    assign clamped = sat_fx(wide, DATA_W);
    assign p       = clamped[DATA_W-1:0];
    assign ovf     = (clamped != wide);

endmodule

// File: rtl/q_update_engine.sv
// Q-learning update: q_new = q_cur + alpha*(reward + gamma*max(q_next) - q_cur).
// Ports: clk, rst; in_valid/in_ready + q_cur, q_next, reward, alpha, gamma,
// terminal; out_valid/out_ready + q_new, best_action, sat_flag.
module q_update_engine #(
    parameter  int DATA_W      = 16,
    parameter  int FRAC_W      = 12,
    parameter  int NUM_ACTIONS = 4,
    localparam int IDX_W       = $clog2(NUM_ACTIONS)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [DATA_W-1:0]             q_cur,
    input  logic [NUM_ACTIONS*DATA_W-1:0] q_next,
    input  logic [DATA_W-1:0]             reward,
    input  logic [DATA_W-1:0]             alpha,
    input  logic [DATA_W-1:0]             gamma,
    input  logic                          terminal,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [DATA_W-1:0]             q_new,
    output logic [IDX_W-1:0]              best_action,
    output logic                          sat_flag
);
    import q_learn_pkg::*;

    state_t                   state;
    logic signed [DATA_W-1:0] qn_r [NUM_ACTIONS];
    logic signed [DATA_W-1:0] q_cur_r;
    logic signed [DATA_W-1:0] reward_r;
    logic signed [DATA_W-1:0] alpha_r;
    logic signed [DATA_W-1:0] gamma_r;
    logic                     terminal_r;
    logic signed [DATA_W-1:0] max_r;
    logic [IDX_W-1:0]         idx_r;
    logic [IDX_W-1:0]         cnt_r;
    logic signed [DATA_W-1:0] tgt_r;

    logic signed [DATA_W-1:0] mul_a;
    logic signed [DATA_W-1:0] mul_b;
    logic signed [DATA_W-1:0] mul_p;
    logic                     mul_ovf;

    logic signed [63:0] diff_raw;
    logic signed [63:0] diff64;
    logic signed [DATA_W-1:0] diff;
    logic               diff_sat;
    logic signed [63:0] tgt_raw;
    logic signed [63:0] tgt64;
    logic               tgt_sat;
    logic signed [63:0] upd_raw;
    logic signed [63:0] upd64;
    logic               upd_sat;

    // One multiplier: gamma*max in TGT, alpha*diff in UPD.
    q_fixed_mul_sat #(
        .DATA_W (DATA_W),
        .FRAC_W (FRAC_W)
    ) u_mul (
        .a   (mul_a),
        .b   (mul_b),
        .p   (mul_p),
        .ovf (mul_ovf)
    );

    always_comb begin
        mul_a = gamma_r;
        mul_b = max_r;
        if (state == UPD) begin
            mul_a = alpha_r;
            mul_b = diff;
        end
    end

    always_comb begin
        diff_raw = 64'(tgt_r) - 64'(q_cur_r);
        diff64   = sat_fx(diff_raw, DATA_W);
        diff     = diff64[DATA_W-1:0];
        diff_sat = (diff64 != diff_raw);

        tgt_raw  = 64'(reward_r) + (terminal_r ? 64'sd0 : 64'(mul_p));
        tgt64    = sat_fx(tgt_raw, DATA_W);
        tgt_sat  = (tgt64 != tgt_raw);

        upd_raw  = 64'(q_cur_r) + 64'(mul_p);
        upd64    = sat_fx(upd_raw, DATA_W);
        upd_sat  = (upd64 != upd_raw);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            in_ready    <= 1'b1;
            out_valid   <= 1'b0;
            q_new       <= '0;
            best_action <= '0;
            sat_flag    <= 1'b0;
            q_cur_r     <= '0;
            reward_r    <= '0;
            alpha_r     <= '0;
            gamma_r     <= '0;
            terminal_r  <= 1'b0;
            max_r       <= '0;
            idx_r       <= '0;
            cnt_r       <= '0;
            tgt_r       <= '0;
            for (int i = 0; i < NUM_ACTIONS; i++)
                qn_r[i] <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        for (int i = 0; i < NUM_ACTIONS; i++)
                            qn_r[i] <= q_next[i*DATA_W +: DATA_W];
                        q_cur_r    <= q_cur;
                        reward_r   <= reward;
                        alpha_r    <= alpha;
                        gamma_r    <= gamma;
                        terminal_r <= terminal;
                        max_r      <= q_next[DATA_W-1:0];
                        idx_r      <= '0;
                        cnt_r      <= IDX_W'(1);
                        sat_flag   <= 1'b0;
                        in_ready   <= 1'b0;
                        state      <= SCAN;
                    end
                end
                SCAN: begin
                    // Strict compare keeps the lowest index on ties.
                    if (qn_r[cnt_r] > max_r) begin
                        max_r <= qn_r[cnt_r];
                        idx_r <= cnt_r;
                    end
                    cnt_r <= cnt_r + 1'b1;
                    if (cnt_r == IDX_W'(NUM_ACTIONS - 1))
                        state <= TGT;
                end
                TGT: begin
                    tgt_r <= tgt64[DATA_W-1:0];
                    // The product is discarded for terminal states.
                    if (tgt_sat || (!terminal_r && mul_ovf))
                        sat_flag <= 1'b1;
                    state <= UPD;
                end
                UPD: begin
                    q_new       <= upd64[DATA_W-1:0];
                    best_action <= idx_r;
                    if (diff_sat || mul_ovf || upd_sat)
                        sat_flag <= 1'b1;
                    out_valid   <= 1'b1;
                    state       <= OUT;
                end
                OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
